handle_stack_unit: RTL and testbench

Stack-pointer unit for the pipelined processor: holds the architectural stack pointer (SP) register and computes the memory address for PUSH/POP, plus the next SP value. Combines the SP register (formerly stackPointer) and the push/pop address/update logic (formerly Handle_Stack) behind one interface. Sits in the memory stage; Stack_Pointer_Out drives the data-memory address mux when a stack op is active.

---
 rtl/stack_pkg.sv | 14 +
 rtl/stack_pointer_reg.sv | 20 ++
 rtl/handle_stack_unit.sv | 80 ++++++++
 tb/tb_handle_stack_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants and types for the stack-pointer unit.
package stack_pkg;

    localparam int          SP_WIDTH = 32;
    localparam logic [31:0] SP_RESET = 32'h000F_FFFF;
    localparam logic [31:0] SP_STEP  = 32'd1;
    localparam logic [31:0] SP_MIN   = 32'h0000_0000;

    localparam logic STACK_PUSH = 1'b0;
    localparam logic STACK_POP  = 1'b1;

    typedef logic [SP_WIDTH-1:0] sp_t;

endpackage

// File: rtl/stack_pointer_reg.sv
// Architectural stack-pointer register: synchronous reset, loads the next SP every cycle.
module stack_pointer_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/handle_stack_unit.sv
// Stack-pointer unit: SP register plus push/pop address and next-SP logic.
// Optional bounds checking is enabled with the STACK_BOUNDS_CHECK_EN macro.
module handle_stack_unit #(
    parameter int                  SP_WIDTH = stack_pkg::SP_WIDTH,
    parameter logic [SP_WIDTH-1:0] SP_RESET = SP_WIDTH'(stack_pkg::SP_RESET),
    parameter logic [SP_WIDTH-1:0] SP_STEP  = SP_WIDTH'(stack_pkg::SP_STEP),
    parameter logic [SP_WIDTH-1:0] SP_MIN   = SP_WIDTH'(stack_pkg::SP_MIN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                IsStackOp,
    input  logic                StackOp,
    output logic [SP_WIDTH-1:0] Stack_Pointer,
    output logic [SP_WIDTH-1:0] Stack_Pointer_Out,
    output logic [SP_WIDTH-1:0] NewSP,
    output logic                Stack_Overflow,
    output logic                Stack_Underflow
);

    import stack_pkg::*;

    logic [SP_WIDTH-1:0] sp;
    logic [SP_WIDTH-1:0] sp_inc;
    logic [SP_WIDTH-1:0] sp_dec;
    logic                is_push;
    logic                is_pop;
    logic                overflow;
    logic                underflow;

    stack_pointer_reg #(
        .WIDTH       (SP_WIDTH),
        .RESET_VALUE (SP_RESET)
    ) u_sp_reg (
        .clk (clk),
        .rst (rst),
        .d   (NewSP),
        .q   (sp)
    );

    assign is_push = IsStackOp && (StackOp == STACK_PUSH);
    assign is_pop  = IsStackOp && (StackOp == STACK_POP);
    assign sp_inc  = sp + SP_STEP;
    assign sp_dec  = sp - SP_STEP;

`ifdef STACK_BOUNDS_CHECK_EN
    // One extra bit catches the borrow/carry that plain modulo arithmetic would hide.
    logic [SP_WIDTH:0] sum_ext;
    logic [SP_WIDTH:0] diff_ext;

    assign sum_ext   = {1'b0, sp} + {1'b0, SP_STEP};
    assign diff_ext  = {1'b0, sp} - {1'b0, SP_STEP};
    assign overflow  = is_push && (diff_ext[SP_WIDTH] || (diff_ext[SP_WIDTH-1:0] < SP_MIN));
    assign underflow = is_pop  && (sum_ext[SP_WIDTH]  || (sum_ext[SP_WIDTH-1:0]  > SP_RESET));
`else
    wire unused_bounds = ^SP_MIN;

    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    // Push is post-decrement, pop is pre-increment; a flagged op still drives its address.
    always_comb begin
        Stack_Pointer_Out = sp;
        NewSP             = sp;
        if (is_push) begin
            NewSP = sp_dec;
        end else if (is_pop) begin
            Stack_Pointer_Out = sp_inc;
            NewSP             = sp_inc;
        end
        if (overflow || underflow) begin
            NewSP = sp;
        end
    end

    assign Stack_Pointer   = sp;
    assign Stack_Overflow  = overflow;
    assign Stack_Underflow = underflow;

endmodule

// File: tb/tb_handle_stack_unit.sv
// Scoreboard bench for handle_stack_unit: a default instance plus a small-SP_RESET instance for wrap/bounds cases.
module tb_handle_stack_unit;

    logic        clk;
    logic        rst;
    logic        is_op_main;
    logic        op_main;
    logic        is_op_wrap;
    logic        op_wrap;

    logic [31:0] sp_main, addr_main, next_main;
    logic        ov_main, un_main;
    logic [31:0] sp_wrap, addr_wrap, next_wrap;
    logic        ov_wrap, un_wrap;

    typedef struct {
        bit          wrap;
        logic [31:0] sp;
        logic [31:0] addr;
        logic [31:0] next;
        logic        ov;
        logic        un;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   passed;

    handle_stack_unit u_dut (
        .clk               (clk),
        .rst               (rst),
        .IsStackOp         (is_op_main),
        .StackOp           (op_main),
        .Stack_Pointer     (sp_main),
        .Stack_Pointer_Out (addr_main),
        .NewSP             (next_main),
        .Stack_Overflow    (ov_main),
        .Stack_Underflow   (un_main)
    );

    handle_stack_unit #(
        .SP_RESET (32'h0000_0002),
        .SP_MIN   (32'h0000_0000)
    ) u_wrap (
        .clk               (clk),
        .rst               (rst),
        .IsStackOp         (is_op_wrap),
        .StackOp           (op_wrap),
        .Stack_Pointer     (sp_wrap),
        .Stack_Pointer_Out (addr_wrap),
        .NewSP             (next_wrap),
        .Stack_Overflow    (ov_wrap),
        .Stack_Underflow   (un_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Drives one cycle of inputs (called just after a rising edge) and queues the expected outputs.
    task automatic applyStimulus(input bit r, input bit wrap, input logic iso, input logic op,
                                 input logic [31:0] esp, input logic [31:0] eaddr,
                                 input logic [31:0] enext, input logic eov, input logic eun,
                                 input string tag);
        exp_t e;
        rst        = r;
        is_op_main = wrap ? 1'b0 : iso;
        op_main    = op;
        is_op_wrap = wrap ? iso : 1'b0;
        op_wrap    = op;
        e.wrap = wrap;
        e.sp   = esp;
        e.addr = eaddr;
        e.next = enext;
        e.ov   = eov;
        e.un   = eun;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so each queued entry is checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.wrap) begin
                checkOutput({e.tag, "/sp"},   sp_wrap,           e.sp);
                checkOutput({e.tag, "/addr"}, addr_wrap,         e.addr);
                checkOutput({e.tag, "/next"}, next_wrap,         e.next);
                checkOutput({e.tag, "/ov"},   {31'd0, ov_wrap},  {31'd0, e.ov});
                checkOutput({e.tag, "/un"},   {31'd0, un_wrap},  {31'd0, e.un});
            end else begin
                checkOutput({e.tag, "/sp"},   sp_main,           e.sp);
                checkOutput({e.tag, "/addr"}, addr_main,         e.addr);
                checkOutput({e.tag, "/next"}, next_main,         e.next);
                checkOutput({e.tag, "/ov"},   {31'd0, ov_main},  {31'd0, e.ov});
                checkOutput({e.tag, "/un"},   {31'd0, un_main},  {31'd0, e.un});
            end
        end
    end

    initial begin
        total      = 0;
        passed     = 0;
        rst        = 1'b1;
        is_op_main = 1'b0;
        op_main    = 1'b0;
        is_op_wrap = 1'b0;
        op_wrap    = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0, 0, 0, 32'h000F_FFFF, 32'h000F_FFFF, 32'h000F_FFFF, 0, 0, "idle_reset");

        applyStimulus(0, 0, 1, 0, 32'h000F_FFFF, 32'h000F_FFFF, 32'h000F_FFFE, 0, 0, "push1");
        applyStimulus(0, 0, 1, 0, 32'h000F_FFFE, 32'h000F_FFFE, 32'h000F_FFFD, 0, 0, "push2");
        applyStimulus(0, 0, 1, 0, 32'h000F_FFFD, 32'h000F_FFFD, 32'h000F_FFFC, 0, 0, "push3");

        applyStimulus(0, 0, 1, 1, 32'h000F_FFFC, 32'h000F_FFFD, 32'h000F_FFFD, 0, 0, "pop1");
        applyStimulus(0, 0, 1, 1, 32'h000F_FFFD, 32'h000F_FFFE, 32'h000F_FFFE, 0, 0, "pop2");
        applyStimulus(0, 0, 1, 1, 32'h000F_FFFE, 32'h000F_FFFF, 32'h000F_FFFF, 0, 0, "pop3");
        applyStimulus(0, 0, 0, 1, 32'h000F_FFFF, 32'h000F_FFFF, 32'h000F_FFFF, 0, 0, "idle_after_pop");

`ifdef STACK_BOUNDS_CHECK_EN
        applyStimulus(0, 0, 1, 1, 32'h000F_FFFF, 32'h0010_0000, 32'h000F_FFFF, 0, 1, "pop_underflow");
        applyStimulus(0, 0, 0, 0, 32'h000F_FFFF, 32'h000F_FFFF, 32'h000F_FFFF, 0, 0, "hold_underflow");
`else
        applyStimulus(0, 0, 1, 1, 32'h000F_FFFF, 32'h0010_0000, 32'h0010_0000, 0, 0, "pop_above_top");
        applyStimulus(0, 0, 1, 0, 32'h0010_0000, 32'h0010_0000, 32'h000F_FFFF, 0, 0, "push_back");
`endif

        for (int i = 0; i < 15; i++)
            applyStimulus(0, 0, 1, 0, 32'h000F_FFFF - 32'(i), 32'h000F_FFFF - 32'(i),
                          32'h000F_FFFE - 32'(i), 0, 0, "push_walk");

        applyStimulus(1, 0, 1, 0, 32'h000F_FFF0, 32'h000F_FFF0, 32'h000F_FFEF, 0, 0, "reset_cycle");
        applyStimulus(0, 0, 0, 0, 32'h000F_FFFF, 32'h000F_FFFF, 32'h000F_FFFF, 0, 0, "after_reset");

        applyStimulus(0, 1, 1, 0, 32'h0000_0002, 32'h0000_0002, 32'h0000_0001, 0, 0, "wrap_push1");
        applyStimulus(0, 1, 1, 0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 0, 0, "wrap_push2");
`ifdef STACK_BOUNDS_CHECK_EN
        applyStimulus(0, 1, 1, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 0, "push_overflow");
        applyStimulus(0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, "hold_overflow");
`else
        applyStimulus(0, 1, 1, 0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, "push_wrap");
        applyStimulus(0, 1, 1, 1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 0, 0, "pop_wrap");
        applyStimulus(0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, "after_wrap");
`endif

        is_op_main = 1'b0;
        is_op_wrap = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() > 0) begin
            total++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
